slt_iter_cmp: RTL and testbench

// Multi-cycle signed/unsigned "set less than" unit for the ALU compare path.

---
 rtl/slt_iter_cmp.sv | 119 +++++++++++
 tb/tb_slt_iter_cmp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/slt_iter_cmp.sv
// Multi-cycle set-less-than unit: subtracts A - B one CHUNK per cycle (LSB first)
// with a registered borrow chain, then reports overflow-correct lt, eq and diff.
module slt_iter_cmp #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] diff
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SUM_W  = CHUNK + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic               sgn_q, sgn_d, carry_q, carry_d, zero_q, zero_d;
  logic               lt_q, lt_d, eq_q, eq_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   sum_c;
  logic               last_c, accept_c, v_ovf_c;

  assign accept_c = in_valid & in_ready;
  assign last_c   = (idx_q == IDX_W'(NCHUNK - 1));
  assign sum_c    = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, ~b_q[idx_q*CHUNK +: CHUNK]}
                  + SUM_W'(carry_q);
  // Signed overflow: operand signs differ and the result sign differs from A.
  assign v_ovf_c  = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sum_c[CHUNK-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    diff_d  = diff_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    if (accept_c) begin
      a_d     = A;
      b_d     = B;
      sgn_d   = is_signed;
      idx_d   = '0;
      carry_d = 1'b1;
      zero_d  = 1'b1;
    end else if (state_q == S_RUN) begin
      diff_d[idx_q*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
      carry_d = sum_c[SUM_W-1];
      zero_d  = zero_q & (sum_c[CHUNK-1:0] == '0);
      idx_d   = last_c ? '0 : idx_q + IDX_W'(1);
      if (last_c) begin
        lt_d = sgn_q ? (sum_c[CHUNK-1] ^ v_ovf_c) : ~sum_c[SUM_W-1];
        eq_d = zero_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b1;
      zero_q  <= 1'b1;
      diff_q  <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      diff_q  <= diff_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign lt   = lt_q;
  assign eq   = eq_q;
  assign diff = diff_q;

endmodule

// File: tb/tb_slt_iter_cmp.sv
// Directed bench for slt_iter_cmp: expected results are queued at accept and
// compared when out_valid rises, plus latency, backpressure and reset-abort checks.
module tb_slt_iter_cmp;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned LAT   = 4;

  typedef struct packed {
    logic             lt;
    logic             eq;
    logic [WIDTH-1:0] diff;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             lt, eq;
  logic [WIDTH-1:0] diff;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  slt_iter_cmp #(.WIDTH(WIDTH), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .lt(lt), .eq(eq), .diff(diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sgn);
    res_t r;
    r.diff = a - b;
    r.eq   = (a == b);
    r.lt   = sgn ? ($signed(a) < $signed(b)) : (a < b);
    return r;
  endfunction

  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    is_signed = sgn;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = {$urandom, $urandom};
    B        = {$urandom, $urandom};
    chk("in_ready_run", 64'(in_ready), 64'(0));
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn,
                       input int hold);
    res_t exp;
    int   lat;
    accept_op(a, b, sgn);
    sb.push_back(model(a, b, sgn));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("out_valid_timeout", 64'(out_valid), 64'(1));
    chk("latency", 64'(lat), 64'(LAT));
    chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = '0;
    chk("lt", 64'(lt), 64'(exp.lt));
    chk("eq", 64'(eq), 64'(exp.eq));
    chk("diff", diff, exp.diff);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_lt", 64'(lt), 64'(exp.lt));
      chk("bp_eq", 64'(eq), 64'(exp.eq));
      chk("bp_diff", diff, exp.diff);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("retired_out_valid", 64'(out_valid), 64'(0));
    chk("retired_in_ready", 64'(in_ready), 64'(1));
    chk("retired_diff_kept", diff, exp.diff);
    chk("retired_lt_kept", 64'(lt), 64'(exp.lt));
  endtask

  initial begin
    logic [WIDTH-1:0] min_s, all1, pat;
    min_s = 64'h8000_0000_0000_0000;
    all1  = '1;
    pat   = 64'h1234_5678_9ABC_DEF0;

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_lt", 64'(lt), 64'(0));
    chk("rst_eq", 64'(eq), 64'(0));
    chk("rst_diff", diff, 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(64'd5, 64'd7, 1'b1, 0);
    chk("t1_diff_const", diff, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(min_s, 64'd1, 1'b1, 0);
    chk("t2_signed_lt_const", 64'(lt), 64'(1));
    do_op(min_s, 64'd1, 1'b0, 0);
    chk("t2_unsigned_diff_const", diff, 64'h7FFF_FFFF_FFFF_FFFF);
    do_op(all1, 64'd0, 1'b1, 0);
    do_op(all1, 64'd0, 1'b0, 0);
    do_op(64'd0, all1, 1'b1, 0);
    do_op(64'd0, all1, 1'b0, 0);
    do_op(pat, pat, 1'b1, 0);
    chk("t4_eq_const", 64'(eq), 64'(1));
    do_op(64'h1_0000, 64'd1, 1'b0, 0);
    chk("t4_borrow_const", diff, 64'h0000_0000_0000_FFFF);

    // Long backpressure followed immediately by another operation.
    do_op(64'd100, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 10);
    do_op(64'd100, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 0);

    // Reset two cycles into an operation aborts it without a result.
    accept_op(64'd3, 64'd9, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_diff", diff, 64'(0));
    chk("abort_lt", 64'(lt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", 64'(out_valid), 64'(0));
    end
    do_op(64'd3, 64'd9, 1'b1, 0);

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? ra : {$urandom, $urandom};
      do_op(ra, rb, 1'(i % 2), i % 3);
    end

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
